// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// multdiv_pkg : shared widths, latencies and FSM state encoding for multdiv_ctrl
// Revision    : 1.0
// ============================================================================
package multdiv_pkg;

    localparam int DATA_W  = 32;
    localparam int ITER    = 32;
    localparam int MUL_LAT = 33;
    localparam int DIV_LAT = 36;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_MUL_IT   = 3'd1;
    localparam state_t S_DIV_NEGA = 3'd2;
    localparam state_t S_DIV_NEGB = 3'd3;
    localparam state_t S_DIV_IT   = 3'd4;
    localparam state_t S_DIV_FIX  = 3'd5;
    localparam state_t S_DONE     = 3'd6;

endpackage
`default_nettype wire

// File: rtl/addsub_32bit.sv
`default_nettype none
// ============================================================================
// addsub_32bit : shared add/subtract datapath; subtract inverts b, carry-in = sub
// Revision     : 1.0
// ============================================================================
module addsub_32bit
    import multdiv_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic [DATA_W-1:0] w_b_eff;

    assign w_b_eff     = b ^ {DATA_W{sub}};
    assign {cout, sum} = {1'b0, a} + {1'b0, w_b_eff} + {{DATA_W{1'b0}}, sub};

endmodule
`default_nettype wire

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// multdiv_ctrl : iterative signed Booth multiplier / restoring divider sharing
//                one adder. Divider compiled in only with MULTDIV_DIV_EN.
// Revision     : 1.0
// ============================================================================
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int COUNT_W = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    input  logic [DATA_W-1:0] data_operandA,
    input  logic [DATA_W-1:0] data_operandB,
    output logic [DATA_W-1:0] data_result,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic              busy
);

    localparam logic [COUNT_W-1:0] C_ITER    = COUNT_W'(ITER);
    localparam logic [COUNT_W-1:0] C_ONE     = COUNT_W'(1);
    localparam logic [DATA_W-1:0]  C_INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t              state_q,  state_d;
    logic [COUNT_W-1:0]  cnt_q,    cnt_d;
    logic [2*DATA_W:0]   prod_q,   prod_d;
    logic [DATA_W-1:0]   a_q,      a_d;
    logic                is_div_q, is_div_d;
    logic                err_q,    err_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                exc_q,    exc_d;
    logic                rdy_q,    rdy_d;
    logic                busy_q,   busy_d;
`ifdef MULTDIV_DIV_EN
    logic [DATA_W-1:0]   b_q,      b_d;
    logic                neg_q,    neg_d;
    logic [DATA_W-1:0]   w_rem_sh;
`endif

    logic [DATA_W-1:0]   w_add_a, w_add_b, w_sum;
    logic                w_sub, w_cout, w_acc_sign;
    logic [DATA_W:0]     w_acc;

    addsub_32bit u_addsub (
        .a    (w_add_a),
        .b    (w_add_b),
        .sub  (w_sub),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // True 33rd bit of the accumulator so a most-negative multiplicand cannot overflow
    assign w_acc_sign = w_add_a[DATA_W-1] ^ w_add_b[DATA_W-1] ^ w_sub ^ w_cout;
`ifdef MULTDIV_DIV_EN
    assign w_rem_sh   = {prod_q[2*DATA_W-2:DATA_W], prod_q[DATA_W-1]};
`endif

    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        w_sub   = 1'b0;
        case (state_q)
            S_MUL_IT: begin
                w_add_a = prod_q[2*DATA_W:DATA_W+1];
                w_add_b = a_q;
                w_sub   = prod_q[1];
            end
`ifdef MULTDIV_DIV_EN
            S_DIV_NEGA: begin
                w_add_b = a_q;
                w_sub   = 1'b1;
            end
            S_DIV_NEGB: begin
                w_add_b = b_q;
                w_sub   = 1'b1;
            end
            S_DIV_IT: begin
                w_add_a = w_rem_sh;
                w_add_b = b_q;
                w_sub   = 1'b1;
            end
            S_DIV_FIX: begin
                w_add_b = prod_q[DATA_W-1:0];
                w_sub   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        a_d      = a_q;
        is_div_d = is_div_q;
        err_d    = err_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        busy_d   = busy_q;
        w_acc    = '0;
`ifdef MULTDIV_DIV_EN
        b_d      = b_q;
        neg_d    = neg_q;
`endif
        case (state_q)
            S_MUL_IT: begin
                if (prod_q[1] ^ prod_q[0]) w_acc = {w_acc_sign, w_sum};
                else                       w_acc = {prod_q[2*DATA_W], prod_q[2*DATA_W:DATA_W+1]};
                prod_d = {w_acc[DATA_W], w_acc, prod_q[DATA_W:1]};
                if (cnt_q != '0) cnt_d = cnt_q - C_ONE;
                if (cnt_q == C_ONE) state_d = S_DONE;
            end
`ifdef MULTDIV_DIV_EN
            S_DIV_NEGA: begin
                if (b_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    prod_d[DATA_W-1:0] = a_q[DATA_W-1] ? w_sum : a_q;
                    state_d            = S_DIV_NEGB;
                end
            end
            S_DIV_NEGB: begin
                b_d     = b_q[DATA_W-1] ? w_sum : b_q;
                cnt_d   = C_ITER;
                state_d = S_DIV_IT;
            end
            S_DIV_IT: begin
                // No borrow (cout=1) means the trial subtract fits: keep it, quotient bit 1
                prod_d = {1'b0, (w_cout ? w_sum : w_rem_sh), prod_q[DATA_W-2:0], w_cout};
                if (cnt_q != '0) cnt_d = cnt_q - C_ONE;
                if (cnt_q == C_ONE) state_d = S_DIV_FIX;
            end
            S_DIV_FIX: begin
                if (neg_q) prod_d[DATA_W-1:0] = w_sum;
                state_d = S_DONE;
            end
`else
            S_DIV_NEGA: state_d = S_DONE;
`endif
            S_DONE: begin
                result_d = is_div_q ? prod_q[DATA_W-1:0] : prod_q[DATA_W:1];
                exc_d    = is_div_q ? err_q
                                    : (prod_q[2*DATA_W:DATA_W+1] != {DATA_W{prod_q[DATA_W]}});
                rdy_d    = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A start pulse aborts whatever is in flight
        if (ctrl_MULT) begin
            state_d  = S_MUL_IT;
            cnt_d    = C_ITER;
            a_d      = data_operandA;
            prod_d   = {{DATA_W{1'b0}}, data_operandB, 1'b0};
            is_div_d = 1'b0;
            err_d    = 1'b0;
            busy_d   = 1'b1;
            rdy_d    = 1'b0;
        end else if (ctrl_DIV) begin
            state_d  = S_DIV_NEGA;
            cnt_d    = '0;
            a_d      = data_operandA;
            prod_d   = '0;
            is_div_d = 1'b1;
            busy_d   = 1'b1;
            rdy_d    = 1'b0;
`ifdef MULTDIV_DIV_EN
            b_d      = data_operandB;
            neg_d    = data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
            err_d    = (data_operandA == C_INT_MIN) && (data_operandB == '1);
`else
            err_d    = 1'b1;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MULTDIV_DIV_EN
            b_q      <= '0;
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            a_q      <= a_d;
            is_div_q <= is_div_d;
            err_q    <= err_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
`ifdef MULTDIV_DIV_EN
            b_q      <= b_d;
            neg_q    <= neg_d;
`endif
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// tb_multdiv_ctrl : directed scoreboard bench for multdiv_ctrl
// Revision        : 1.0
// ============================================================================
module tb_multdiv_ctrl;

`ifdef MULTDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif
    localparam int MUL_CLKS = 33;
    localparam int DIV_CLKS = 36;
    localparam int REJ_CLKS = 2;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV  = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int cyc      = 0;
    int n_checks = 0;
    int n_err    = 0;
    int t_start  = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        exc;
        logic [15:0] lat;
    } exp_t;

    exp_t sb[$];

    multdiv_ctrl #(.COUNT_W(6)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input bit mul, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint p;
        int     qa, qb;
        if (mul) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            e.res = p[31:0];
            e.exc = (p != longint'($signed(p[31:0])));
            e.lat = 16'(MUL_CLKS);
        end else if (!DIV_ON || b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
            e.lat = 16'(REJ_CLKS);
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
            e.lat = 16'(DIV_CLKS);
        end else begin
            qa    = $signed(a);
            qb    = $signed(b);
            e.res = 32'(qa / qb);
            e.exc = 1'b0;
            e.lat = 16'(DIV_CLKS);
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the sampling edge
    task automatic start(input bit mul, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = mul;
        ctrl_DIV      = !mul;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        t_start   = cyc;
    endtask

    task automatic launch(input bit mul, input logic [31:0] a, input logic [31:0] b, input int extra);
        exp_t e;
        e     = model(mul, a, b);
        e.lat = e.lat + 16'(extra);
        sb.push_back(e);
        start(mul, a, b);
    endtask

    task automatic collect(input string tag, input int t_ref);
        exp_t e;
        int   n = 0;
        while (data_resultRDY !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        e = sb.pop_front();
        chk({tag, " rdy_clock"}, 32'(cyc - t_ref), {16'd0, e.lat});
        chk({tag, " result"}, data_result, e.res);
        chk({tag, " exception"}, {31'd0, data_exception}, {31'd0, e.exc});
        chk({tag, " busy_at_rdy"}, {31'd0, busy}, 32'd0);
        @(negedge clock);
        chk({tag, " rdy_width"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    initial begin
        int t_ref;
        int stray;

        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset result", data_result, 32'd0);
        chk("reset exception", {31'd0, data_exception}, 32'd0);
        chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        launch(1'b1, 32'd7, 32'hFFFF_FFFD, 0);
        chk("mul busy after start", {31'd0, busy}, 32'd1);
        collect("mul 7*-3", t_start);

        launch(1'b1, 32'h0001_0000, 32'h0001_0000, 0);
        collect("mul 2^16*2^16", t_start);

        launch(1'b1, 32'h8000_0000, 32'h8000_0000, 0);
        collect("mul min*min", t_start);

        launch(1'b0, 32'hFFFF_FF9C, 32'd7, 0);
        chk("div busy after start", {31'd0, busy}, 32'd1);
        collect("div -100/7", t_start);

        launch(1'b0, 32'd5, 32'd0, 0);
        collect("div 5/0", t_start);

        launch(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        collect("div min/-1", t_start);

        // Multiply restarted by a divide on clock 10
        start(1'b1, 32'd3, 32'd4);
        t_ref = t_start;
        stray = 0;
        repeat (9) begin
            if (data_resultRDY !== 1'b0) stray++;
            @(negedge clock);
        end
        launch(1'b0, 32'd9, 32'd3, 10);
        collect("restart mul->div", t_ref);
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) stray++;
        end
        chk("restart single rdy", 32'(stray), 32'd0);

        // Reset asserted between clock edges in the middle of a divide
        start(1'b0, 32'd1000, 32'd3);
        repeat (DIV_ON ? 5 : 0) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset result", data_result, 32'd0);
        chk("midreset exception", {31'd0, data_exception}, 32'd0);
        chk("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        chk("start ignored in reset busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        stray   = 0;
        repeat (60) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) stray++;
        end
        chk("no activity after reset", 32'(stray), 32'd0);

        launch(1'b1, 32'hFFFF_FFFA, 32'd7, 0);
        collect("mul -6*7 after reset", t_start);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
